sram_page_manager: RTL

Per-SRAM bookkeeping block, successor to the fixed 16-port/2048-page state block. It owns the free-page list, per-port page counters, the free-space count, the jump table and (optionally) the ECC storage for one data SRAM. It sits between the write/read schedulers and the data SRAM. Port count, depth and widths are parametrised. It adds a self-initialising free list, a registered allocation handshake and overflow/underflow error reporting.

---
 rtl/sram_page_manager_pkg.sv | 23 ++
 rtl/free_page_fifo.sv | 62 ++++++
 rtl/sram_page_manager.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sram_page_manager_pkg.sv
// Shared types, width helpers and default sizing for the SRAM page manager.
package sram_page_manager_pkg;

  typedef enum logic {INIT = 1'b0, READY = 1'b1} pm_state_e;

  localparam int DEF_NUM_PORTS = 16;
  localparam int DEF_DEPTH     = 2048;
  localparam int DEF_JT_W      = 16;
  localparam int DEF_ECC_W     = 8;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int port_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/free_page_fifo.sv
// Free-page ring buffer: self-fills with 0..DEPTH-1 during INIT, then pops
// from head (registered read) and pushes at tail. Occupancy is tracked outside.
module free_page_fifo #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              pop,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              init_last,
  output logic [ADDR_W-1:0] pop_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;

  assign init_last = init && (fill_q == LAST);
  assign pop_addr  = pop_addr_q;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    pop_addr_d = pop_addr_q;
    if (init) begin
      fill_d = (fill_q == LAST) ? '0 : fill_q + 1'b1;
    end else begin
      if (pop) begin
        pop_addr_d = mem[head_q];
        head_d     = (head_q == LAST) ? '0 : head_q + 1'b1;
      end
      if (push) tail_d = (tail_q == LAST) ? '0 : tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      pop_addr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      pop_addr_q <= pop_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init)      mem[fill_q] <= fill_q;
    else if (push) mem[tail_q] <= push_addr;
  end

endmodule

// File: rtl/sram_page_manager.sv
// Per-SRAM page bookkeeping: free list, per-port counters, free space, jump table
// and optional ECC storage (enabled by SRAM_PAGE_MANAGER_ECC_EN).
module sram_page_manager
  import sram_page_manager_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_W    = addr_width(DEPTH),
  parameter int PORT_W    = port_width(NUM_PORTS),
  parameter int CNT_W     = cnt_width(DEPTH),
  parameter int JT_W      = DEF_JT_W,
  parameter int ECC_W     = DEF_ECC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              alloc_req,
  input  logic [PORT_W-1:0] alloc_port,
  output logic              alloc_valid,
  output logic [ADDR_W-1:0] alloc_addr,
  output logic              alloc_err,
  input  logic              free_req,
  input  logic [ADDR_W-1:0] free_addr,
  input  logic [PORT_W-1:0] free_port,
  output logic              free_err,
  output logic [CNT_W-1:0]  free_space,
  input  logic [PORT_W-1:0] query_port,
  output logic [CNT_W-1:0]  query_pages,
  input  logic              jt_wr_en,
  input  logic [ADDR_W-1:0] jt_wr_addr,
  input  logic [JT_W-1:0]   jt_din,
  input  logic              jt_rd_en,
  input  logic [ADDR_W-1:0] jt_rd_addr,
  output logic [JT_W-1:0]   jt_dout,
  input  logic              ecc_wr_en,
  input  logic [ADDR_W-1:0] ecc_wr_addr,
  input  logic [ECC_W-1:0]  ecc_din,
  input  logic              ecc_rd_en,
  input  logic [ADDR_W-1:0] ecc_rd_addr,
  output logic [ECC_W-1:0]  ecc_dout
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  pm_state_e state_q, state_d;
  logic [CNT_W-1:0] free_space_q, free_space_d;
  logic [NUM_PORTS-1:0][CNT_W-1:0] port_pages_q, port_pages_d;
  logic alloc_valid_q, alloc_valid_d, alloc_err_q, alloc_err_d, free_err_q, free_err_d;
  logic grant, accept, init_last, sat_err, inc, dec;

  assign ready       = (state_q == READY);
  assign grant       = ready && alloc_req && (free_space_q != '0);
  assign accept      = ready && free_req && (free_space_q != FULL);
  assign free_space  = free_space_q;
  assign alloc_valid = alloc_valid_q;
  assign alloc_err   = alloc_err_q;
  assign free_err    = free_err_q;
  assign query_pages = (int'(query_port) < NUM_PORTS) ? port_pages_q[query_port] : '0;

  free_page_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (state_q == INIT),
    .pop       (grant),
    .push      (accept),
    .push_addr (free_addr),
    .init_last (init_last),
    .pop_addr  (alloc_addr)
  );

  always_comb begin
    state_d      = state_q;
    free_space_d = free_space_q;
    case (state_q)
      INIT: if (init_last) begin
        state_d      = READY;
        free_space_d = FULL;
      end
      READY: begin
        if (grant && !accept)      free_space_d = free_space_q - 1'b1;
        else if (accept && !grant) free_space_d = free_space_q + 1'b1;
      end
      default: state_d = INIT;
    endcase
  end

  // A same-port grant+free cancels out; a lone free on an empty counter saturates.
  always_comb begin
    port_pages_d = port_pages_q;
    sat_err      = 1'b0;
    inc          = 1'b0;
    dec          = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      inc = grant  && (alloc_port == PORT_W'(i));
      dec = accept && (free_port  == PORT_W'(i));
      if (inc && !dec) begin
        port_pages_d[i] = port_pages_q[i] + 1'b1;
      end else if (dec && !inc) begin
        if (port_pages_q[i] == '0) sat_err = 1'b1;
        else port_pages_d[i] = port_pages_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    alloc_valid_d = grant;
    alloc_err_d   = alloc_req && !grant;
    free_err_d    = (free_req && !accept) || sat_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      free_space_q  <= '0;
      port_pages_q  <= '0;
      alloc_valid_q <= 1'b0;
      alloc_err_q   <= 1'b0;
      free_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      free_space_q  <= free_space_d;
      port_pages_q  <= port_pages_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_err_q   <= alloc_err_d;
      free_err_q    <= free_err_d;
    end
  end

  // Jump table: read-before-write, output holds while the read enable is low.
  logic [JT_W-1:0] jt_mem [DEPTH];
  logic [JT_W-1:0] jt_dout_q, jt_dout_d;

  assign jt_dout   = jt_dout_q;
  assign jt_dout_d = jt_rd_en ? jt_mem[jt_rd_addr] : jt_dout_q;

  always_ff @(posedge clk) if (jt_wr_en) jt_mem[jt_wr_addr] <= jt_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) jt_dout_q <= '0;
    else        jt_dout_q <= jt_dout_d;
  end

`ifdef SRAM_PAGE_MANAGER_ECC_EN
  logic [ECC_W-1:0] ecc_mem [DEPTH];
  logic [ECC_W-1:0] ecc_dout_q, ecc_dout_d;

  assign ecc_dout   = ecc_dout_q;
  assign ecc_dout_d = ecc_rd_en ? ecc_mem[ecc_rd_addr] : ecc_dout_q;

  always_ff @(posedge clk) if (ecc_wr_en) ecc_mem[ecc_wr_addr] <= ecc_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecc_dout_q <= '0;
    else        ecc_dout_q <= ecc_dout_d;
  end
`else
  logic unused_ecc;
  assign unused_ecc = ^{ecc_wr_en, ecc_wr_addr, ecc_din, ecc_rd_en, ecc_rd_addr};
  assign ecc_dout   = '0;
`endif

endmodule
